// File: rtl/stb_pkg.sv
// rtl/stb_pkg.sv - shared types, defaults and saturation helper for stoch_to_bin
//
// Purpose : FSM state encoding, default parameter values and the count-to-output
//           saturation function used by the stochastic-to-binary decoder.
// Ports   : none (package)

package stb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } stb_state_e;

  localparam int STB_STREAM_LEN_DFLT = 16;
  localparam int STB_OUT_W_DFLT      = 4;

  // Clamp a raw count to the largest value representable in out_w bits.
  function automatic logic [31:0] sat_count(input logic [31:0] cnt, input int out_w);
    logic [31:0] max_v;
    max_v = (32'd1 << out_w) - 32'd1;
    return (cnt > max_v) ? max_v : cnt;
  endfunction

endpackage

// File: rtl/sn_window_ctr.sv
// rtl/sn_window_ctr.sv - bit index counter for one stochastic window
//
// Purpose : counts sampled bits inside a window and flags the last bit position.
// Ports   : i_clk_stb   in  clock, rising edge
//           i_rst_n_stb in  asynchronous active-low reset
//           i_clr       in  clear index to 0 (priority over i_en)
//           i_en        in  advance index by one
//           o_term      out index == STREAM_LEN-1 (current bit is the last one)

module sn_window_ctr #(
  parameter int STREAM_LEN = 16,
  localparam int IDX_W = $clog2(STREAM_LEN)
) (
  input  logic i_clk_stb,
  input  logic i_rst_n_stb,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge i_clk_stb or negedge i_rst_n_stb) begin
    if (!i_rst_n_stb) begin
      idx_q <= '0;
    end else if (i_clr) begin
      idx_q <= '0;
    end else if (i_en) begin
      // STREAM_LEN is a power of two, so wrap after the last bit is natural.
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign o_term = (idx_q == IDX_W'(STREAM_LEN - 1));

endmodule

// File: rtl/stoch_to_bin.sv
// rtl/stoch_to_bin.sv - stochastic-to-binary decoder (popcount over a window)
//
// Purpose : counts 1s in a fixed-length stochastic bit stream, one bit per clock,
//           and presents the raw and saturated binary magnitude.
// Ports   : i_clk_stb   in  clock, rising edge
//           i_rst_n_stb in  asynchronous active-low reset
//           i_start_stb in  pulse: open a new window (restarts an open one)
//           i_stop_stb  in  pulse: close the current window early
//           i_sn_bit    in  stochastic stream bit, sampled only while busy
//           o_busy      out window open
//           o_valid     out one-cycle pulse, result registers just updated
//           o_count     out number of 1s in the last window
//           o_x_bn      out o_count saturated to OUT_W bits
//           o_partial   out last window was closed early by i_stop_stb

module stoch_to_bin
  import stb_pkg::*;
#(
  parameter int STREAM_LEN = STB_STREAM_LEN_DFLT,
  parameter int OUT_W      = STB_OUT_W_DFLT,
  localparam int CNT_W     = $clog2(STREAM_LEN + 1)
) (
  input  logic             i_clk_stb,
  input  logic             i_rst_n_stb,
  input  logic             i_start_stb,
  input  logic             i_stop_stb,
  input  logic             i_sn_bit,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic [OUT_W-1:0] o_x_bn,
  output logic             o_partial
);

  stb_state_e       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] x_bn_q;
  logic             partial_q, partial_d;
  logic             load_res;
  logic             win_clr, win_en, idx_term;

  sn_window_ctr #(
    .STREAM_LEN (STREAM_LEN)
  ) u_win_ctr (
    .i_clk_stb   (i_clk_stb),
    .i_rst_n_stb (i_rst_n_stb),
    .i_clr       (win_clr),
    .i_en        (win_en),
    .o_term      (idx_term)
  );

  // Accumulator including the bit on the wire this cycle; the result registers
  // load from this so the closing bit is always counted.
  assign acc_sum = acc_q + CNT_W'(i_sn_bit);

  always_ff @(posedge i_clk_stb or negedge i_rst_n_stb) begin
    if (!i_rst_n_stb) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    win_clr   = 1'b0;
    win_en    = 1'b0;
    load_res  = 1'b0;
    partial_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start_stb) begin
          state_d = ACC;
          acc_d   = '0;
          win_clr = 1'b1;
        end
      end
      ACC: begin
        if (i_start_stb) begin
          // Restart wins over stop; the bit on the wire is discarded.
          acc_d   = '0;
          win_clr = 1'b1;
        end else begin
          acc_d  = acc_sum;
          win_en = 1'b1;
          if (idx_term) begin
            state_d  = DONE;
            load_res = 1'b1;
          end else if (i_stop_stb) begin
            state_d   = DONE;
            load_res  = 1'b1;
            partial_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (i_start_stb) begin
          state_d = ACC;
          acc_d   = '0;
          win_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_stb or negedge i_rst_n_stb) begin
    if (!i_rst_n_stb) begin
      count_q   <= '0;
      x_bn_q    <= '0;
      partial_q <= 1'b0;
    end else if (load_res) begin
      count_q   <= acc_sum;
      x_bn_q    <= OUT_W'(sat_count(32'(acc_sum), OUT_W));
      partial_q <= partial_d;
    end
  end

  assign o_busy    = (state_q == ACC);
  assign o_valid   = (state_q == DONE);
  assign o_count   = count_q;
  assign o_x_bn    = x_bn_q;
  assign o_partial = partial_q;

endmodule
